// File: rtl/weight_fetch_seq_pkg.sv
// Shared types for the layer-1 weight fetch sequencer.
//   wf_state_t : sequencer FSM state encoding
//   WF_STALL_W : width of the optional stall counter (WF_STALL_CNT_EN)
package wf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } wf_state_t;

  localparam int WF_STALL_W = 16;

endpackage

// File: rtl/weight_fetch_seq_if.sv
// Weight-pair valid/ready stream from the sequencer to the layer-1 MAC array.
//   w_valid : pair valid           (master -> slave)
//   w_ready : downstream accepts   (slave  -> master)
//   w0, w1  : bank-0 / bank-1 weights
//   w_last  : final beat of the job
interface weight_fetch_seq_if #(
  parameter int WIDTH = 16
);
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] w1;
  logic             w_last;

  modport master (output w_valid, output w0, output w1, output w_last, input w_ready);
  modport slave  (input w_valid, input w0, input w1, input w_last, output w_ready);
endinterface

// File: rtl/weight_fetch_seq_out_reg.sv
// wf_out_reg: registered output stage of the weight stream.
// Loads a new pair whenever the stage is empty or its current pair is being
// taken in the same cycle; otherwise holds (stable under backpressure).
//   clk, rst      : clock, async active-high reset
//   in_valid_i    : a new pair is offered this cycle
//   d0_i, d1_i    : bank-0/bank-1 data to capture
//   dlast_i       : last-beat flag to capture
//   load_ok_o     : stage can accept a pair this cycle
//   w             : stream master side
module wf_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  d0_i,
  input  logic [WIDTH-1:0]  d1_i,
  input  logic              dlast_i,
  output logic              load_ok_o,
  weight_fetch_seq_if.master w
);

  logic             valid_q;
  logic             last_q;
  logic [WIDTH-1:0] w0_q;
  logic [WIDTH-1:0] w1_q;

  assign load_ok_o = !valid_q || w.w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else if (in_valid_i && load_ok_o) begin
      valid_q <= 1'b1;
      last_q  <= dlast_i;
      w0_q    <= d0_i;
      w1_q    <= d1_i;
    end else if (valid_q && w.w_ready) begin
      // taken with nothing behind it: empty the stage, keep the data bits
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign w.w_valid = valid_q;
  assign w.w_last  = last_q;
  assign w.w0      = w0_q;
  assign w.w1      = w1_q;

endmodule

// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq: drives the two read addresses of the layer-1 dual-bank
// weight ROM and streams one weight pair per beat to the MAC array.
// A job is len consecutive entries per bank from independent base addresses,
// wrapping modulo the bank depth.
//   clk, rst            : clock, async active-high reset
//   start               : job request (ignored while busy)
//   base_a, base_b, len : job parameters, sampled on start accept
//   busy, done          : job in progress / one-cycle completion pulse
//   address, address2   : ROM read addresses (bank 0 / bank 1)
//   rom_data0/1         : combinational ROM bank outputs
//   w                   : weight stream (master)
//   stall_cnt           : backpressure cycle count, only with WF_STALL_CNT_EN
//
// state | meaning
// IDLE  | waiting for start; addresses hold
// FETCH | loading pairs into the output stage, idx advancing
// DRAIN | last pair loaded, waiting for it to be taken
module weight_fetch_seq
  import wf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ADDR  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR-1:0]   base_a,
  input  logic [ADDR-1:0]   base_b,
  input  logic [ADDR:0]     len,
  output logic              busy,
  output logic              done,
  output logic [ADDR-1:0]   address,
  output logic [ADDR-1:0]   address2,
  input  logic [WIDTH-1:0]  rom_data0,
  input  logic [WIDTH-1:0]  rom_data1,
  weight_fetch_seq_if.master w
`ifdef WF_STALL_CNT_EN
  ,
  output logic [WF_STALL_W-1:0] stall_cnt
`endif
);

  wf_state_t       state_q, state_d;
  logic [ADDR-1:0] base_a_q, base_a_d;
  logic [ADDR-1:0] base_b_q, base_b_d;
  logic [ADDR:0]   len_q, len_d;
  logic [ADDR:0]   idx_q, idx_d;
  logic [ADDR-1:0] addr0_q, addr0_d;
  logic [ADDR-1:0] addr1_q, addr1_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fetch_en;
  logic            load_ok;
  logic            last_beat;

  assign last_beat = (idx_q == (len_q - {{ADDR{1'b0}}, 1'b1}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    idx_d    = idx_q;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fetch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = len;
          idx_d    = '0;
          // present entry 0 now so the ROM data is ready for the first load
          addr0_d  = base_a;
          addr1_d  = base_b;
          if (len != '0) begin
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        fetch_en = 1'b1;
        if (load_ok) begin
          idx_d   = idx_q + {{ADDR{1'b0}}, 1'b1};
          // addresses track the next idx so data is valid for the next load
          addr0_d = base_a_q + idx_d[ADDR-1:0];
          addr1_d = base_b_q + idx_d[ADDR-1:0];
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w.w_valid && w.w_ready) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  wf_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (fetch_en),
    .d0_i       (rom_data0),
    .d1_i       (rom_data1),
    .dlast_i    (last_beat),
    .load_ok_o  (load_ok),
    .w          (w)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign address  = addr0_q;
  assign address2 = addr1_q;

`ifdef WF_STALL_CNT_EN
  logic [WF_STALL_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (busy_q && w.w_valid && !w.w_ready && (stall_q != {WF_STALL_W{1'b1}})) begin
      stall_q <= stall_q + {{(WF_STALL_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
